// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Receives a program over a byte-wide valid/ready link and writes it into an
// attached 16-bit instruction memory, then hands the memory address bus to
// the processor and enables it.
//
// Stream: length (lo, hi), then `length` words, each low byte then high byte.
// Optional trailing 8-bit checksum when LOADER_CHECKSUM_EN is defined.
//
// Configuration macro:
//   LOADER_CHECKSUM_EN  - require a trailing checksum byte (mod-256 sum of
//                         both length bytes and all data bytes).
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle load request (honoured in IDLE/RUN/ERR)
//   rx_data      in   [7:0] host byte
//   rx_valid     in   host byte valid
//   rx_ready     out  loader accepts a byte this cycle
//   cpu_addr     in   [15:0] processor fetch address
//   mem_write_en out  instruction memory write enable
//   mem_addr     out  [15:0] instruction memory address
//   mem_instr_in out  [15:0] instruction memory write data
//   cpu_run      out  processor enable (registered)
//   busy         out  load in progress
//   error        out  load failed
//
// State table
//   state  | meaning
//   IDLE   | waiting for start after reset
//   LEN_LO | expecting length low byte
//   LEN_HI | expecting length high byte, range-checks length
//   DAT_LO | expecting word low byte
//   DAT_HI | expecting word high byte
//   WR     | single-cycle memory write of the assembled word
//   CHK    | expecting checksum byte (checksum build only)
//   RUN    | program loaded, processor owns mem_addr
//   ERR    | length overflow or checksum mismatch
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int MEM_DEPTH = 181
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [15:0] cpu_addr,
    output logic        mem_write_en,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_instr_in,
    output logic        cpu_run,
    output logic        busy,
    output logic        error
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LEN_LO = 4'd1;
    localparam logic [3:0] S_LEN_HI = 4'd2;
    localparam logic [3:0] S_DAT_LO = 4'd3;
    localparam logic [3:0] S_DAT_HI = 4'd4;
    localparam logic [3:0] S_WR     = 4'd5;
    localparam logic [3:0] S_CHK    = 4'd6;
    localparam logic [3:0] S_RUN    = 4'd7;
    localparam logic [3:0] S_ERR    = 4'd8;

    localparam logic [16:0] DEPTH_W = 17'(MEM_DEPTH);

`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] S_DONE = S_CHK;
`else
    localparam logic [3:0] S_DONE = S_RUN;
`endif

    logic [3:0]  state, state_nx;
    logic [15:0] idx;
    logic [15:0] len;
    logic [7:0]  dat_lo, dat_hi;
    logic        cpu_run_r;
    logic        accept;
    logic        restart;
    logic [15:0] len_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign rx_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DAT_LO) || (state == S_DAT_HI) ||
                      (state == S_CHK);
    assign busy     = rx_ready || (state == S_WR);
    assign error    = (state == S_ERR);
    assign mem_write_en = (state == S_WR);
    // The processor owns the address bus only while running.
    assign mem_addr     = (state == S_RUN) ? cpu_addr : idx;
    assign mem_instr_in = {dat_hi, dat_lo};
    assign cpu_run      = cpu_run_r;

    assign accept   = rx_valid && rx_ready;
    assign restart  = start && ((state == S_IDLE) || (state == S_RUN) ||
                                (state == S_ERR));
    assign len_full = {rx_data, len[7:0]};

    always_comb begin
        state_nx = state;
        if (restart) begin
            state_nx = S_LEN_LO;
        end else begin
            case (state)
                S_LEN_LO: if (accept) state_nx = S_LEN_HI;
                S_LEN_HI: begin
                    if (accept) begin
                        if (len_full == 16'd0)
                            state_nx = S_DONE;
                        else if ({1'b0, len_full} > DEPTH_W)
                            state_nx = S_ERR;
                        else
                            state_nx = S_DAT_LO;
                    end
                end
                S_DAT_LO: if (accept) state_nx = S_DAT_HI;
                S_DAT_HI: if (accept) state_nx = S_WR;
                S_WR:     state_nx = (idx == len - 16'd1) ? S_DONE : S_DAT_LO;
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) state_nx = (rx_data == csum) ? S_RUN : S_ERR;
                end
`endif
                default:  state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= 16'd0;
            len       <= 16'd0;
            dat_lo    <= 8'd0;
            dat_hi    <= 8'd0;
            cpu_run_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            state     <= state_nx;
            // Registered so it tracks the RUN state without a decode delay.
            cpu_run_r <= (state_nx == S_RUN);
            if (restart) begin
                idx  <= 16'd0;
                len  <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
                csum <= 8'd0;
`endif
            end else begin
                if (accept) begin
                    case (state)
                        S_LEN_LO: len[7:0]  <= rx_data;
                        S_LEN_HI: len[15:8] <= rx_data;
                        S_DAT_LO: dat_lo    <= rx_data;
                        S_DAT_HI: dat_hi    <= rx_data;
                        default:  ;
                    endcase
`ifdef LOADER_CHECKSUM_EN
                    if (state != S_CHK)
                        csum <= csum + rx_data;
`endif
                end
                if ((state == S_WR) && (idx != len - 16'd1))
                    idx <= idx + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Scoreboard bench: each load pushes its expected memory writes into a
// queue; an independent monitor pops and compares on every mem_write_en.
// Expected writes and end status come from a stream-level model of the
// load protocol. Honours LOADER_CHECKSUM_EN like the design.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int DEPTH = 181;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] cpu_addr = 16'd0;
    logic        mem_write_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_instr_in;
    logic        cpu_run;
    logic        busy;
    logic        error;

    instr_mem_loader #(.MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .cpu_addr     (cpu_addr),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_instr_in (mem_instr_in),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] q_addr[$];
    logic [15:0] q_data[$];
    logic [15:0] words[$];
    logic [15:0] ref_mem [0:255];
    logic [15:0] mem [0:255];
    logic [15:0] rdata;
    logic [15:0] ea, ed;

    // Attached memory: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[7:0]] <= mem_instr_in;
        rdata <= mem[mem_addr[7:0]];
    end

    // Write monitor
    always @(negedge clk) begin
        if (rst_n && mem_write_en) begin
            total++;
            if (q_addr.size() == 0) begin
                bad++;
                $display("FAIL spurious_write got addr=%0h data=%0h, expected no write",
                         mem_addr, mem_instr_in);
            end else begin
                ea = q_addr.pop_front();
                ed = q_data.pop_front();
                if (mem_addr !== ea || mem_instr_in !== ed) begin
                    bad++;
                    $display("FAIL write got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             mem_addr, mem_instr_in, ea, ed);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            rx_valid = 1'b0;
            step();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            step();
            n++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout got=0 expected=1");
        end
        step();
        rx_valid = 1'b0;
    endtask

    // Loads `len` words from `words` (ignored when len exceeds DEPTH).
    task automatic run_load(input string nm, input logic [15:0] len,
                            input bit gap, input bit bad_sum);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        bit         exp_run;
        int         n;
        bytes.push_back(len[7:0]);
        bytes.push_back(len[15:8]);
        exp_run = (int'(len) <= DEPTH);
        if (exp_run) begin
            for (int i = 0; i < int'(len); i++) begin
                bytes.push_back(words[i][7:0]);
                bytes.push_back(words[i][15:8]);
                q_addr.push_back(16'(i));
                q_data.push_back(words[i]);
                ref_mem[i] = words[i];
            end
            if (CHK_EN) begin
                sum = 8'd0;
                foreach (bytes[k]) sum = sum + bytes[k];
                if (bad_sum) begin
                    sum = sum + 8'd1;
                    exp_run = 1'b0;
                end
                bytes.push_back(sum);
            end
        end
        pulse_start();
        chk({nm, "_busy_rdy"}, {30'd0, busy, rx_ready}, 32'd3);
        foreach (bytes[k]) send_byte(bytes[k], gap);
        n = 0;
        while (!(cpu_run || error) && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, exp_run});
        chk({nm, "_error"}, {31'd0, error}, {31'd0, !exp_run});
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_writes_left"}, q_addr.size(), 32'd0);
    endtask

    task automatic rand_words(input int len);
        words.delete();
        for (int i = 0; i < len; i++) words.push_back(16'($urandom));
    endtask

    initial begin
        int n;
        step();
        step();
        chk("reset_outputs",
            {rx_ready, mem_write_en, cpu_run, busy, error, mem_addr, mem_instr_in},
            32'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_after_release", {29'd0, busy, cpu_run, error}, 32'd0);

        // Reference two-word program
        words.delete();
        words.push_back(16'h0026);
        words.push_back(16'h0101);
        run_load("two_word", 16'd2, 1'b0, 1'b0);

        // Length overflow
        run_load("overflow", 16'd182, 1'b0, 1'b0);
        chk("overflow_rx_ready", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 4; i++) step();
        chk("err_hold", {30'd0, error, rx_ready}, 32'd2);
        rx_valid = 1'b0;

        // Throttled host link
        rand_words(3);
        run_load("gapped", 16'd3, 1'b1, 1'b0);

        // Reset after the first of three words
        rand_words(3);
        pulse_start();
        send_byte(8'd3, 1'b0);
        send_byte(8'd0, 1'b0);
        send_byte(words[0][7:0], 1'b0);
        send_byte(words[0][15:8], 1'b0);
        q_addr.push_back(16'd0);
        q_data.push_back(words[0]);
        n = 0;
        while (q_addr.size() != 0 && n < 10) begin
            step();
            n++;
        end
        chk("first_word_written", q_addr.size(), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_load_reset_outputs",
            {rx_ready, mem_write_en, cpu_run, busy, error, mem_addr, mem_instr_in},
            32'd0);
        q_addr.delete();
        q_data.delete();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("idle_after_mid_reset", {29'd0, busy, cpu_run, error}, 32'd0);
        rand_words(3);
        run_load("reload", 16'd3, 1'b0, 1'b0);

        // Randomised programs
        for (int it = 0; it < 10; it++) begin
            int l;
            l = $urandom_range(0, 6);
            rand_words(l);
            run_load("rand", 16'(l), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Full-depth program and processor fetch path
        rand_words(DEPTH);
        run_load("full_depth", 16'(DEPTH), 1'b0, 1'b0);
        cpu_addr = 16'(DEPTH - 1);
        #1;
        chk("fetch_last_addr", {16'd0, mem_addr}, DEPTH - 1);
        step();
        chk("fetch_last_data", {16'd0, rdata}, {16'd0, ref_mem[DEPTH - 1]});
        cpu_addr = 16'd5;
        #1;
        chk("fetch_addr5", {16'd0, mem_addr}, 32'd5);
        step();
        chk("fetch_data5", {16'd0, rdata}, {16'd0, ref_mem[5]});

        // Restart from RUN
        pulse_start();
        chk("restart_from_run", {30'd0, cpu_run, rx_ready}, 32'd1);
        send_byte(8'd0, 1'b0);
        send_byte(8'd0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'd0, 1'b0);
`endif
        step();
        chk("empty_program_run", {30'd0, cpu_run, error}, 32'd2);

`ifdef LOADER_CHECKSUM_EN
        rand_words(4);
        run_load("bad_checksum", 16'd4, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: MEM_DEPTH, default 181, number of 16-bit words in the attached instruction memory.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  one-cycle pulse requesting a program load.
REQ-005 Port: rx_data  input  8  program byte stream from the host link.
REQ-006 Port: rx_valid  input  1  rx_data valid.
REQ-007 Port: rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid and rx_ready are both high.
REQ-008 Port: cpu_addr  input  16  processor fetch address.
REQ-009 Port: mem_write_en  output  1  instruction memory write enable.
REQ-010 Port: mem_addr  output  16  instruction memory address.
REQ-011 Port: mem_instr_in  output  16  instruction memory write data.
REQ-012 Port: cpu_run  output  1  processor enable; high only in RUN.
REQ-013 Port: busy  output  1  high in any load state (LEN_LO through CHK).
REQ-014 Port: error  output  1  high only in ERR.

Function
REQ-015 States: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WR, CHK, RUN, ERR.
REQ-016 IDLE or RUN or ERR with start=1 -> LEN_LO next cycle, word index cleared; start is ignored in all other states.
REQ-017 rx_ready = 1 in LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHK; 0 elsewhere; a state holds indefinitely while rx_valid=0.
REQ-018 Stream format, little-endian: length low byte, length high byte, then length words each sent low byte then high byte.
REQ-019 LEN_HI accept: len=0 -> RUN (no writes); len>MEM_DEPTH -> ERR; else -> DAT_LO.
REQ-020 DAT_HI accept -> WR; WR lasts exactly one cycle with mem_write_en=1, mem_addr=index, mem_instr_in={hi,lo}.
REQ-021 After WR: index==len-1 -> end-of-data (REQ-033); else index+1, -> DAT_LO.
REQ-022 Exactly one memory write per word; mem_write_en=0 in every state except WR.
REQ-023 Outside RUN, mem_addr is driven from the loader index register; in RUN, mem_addr = cpu_addr combinationally, so the memory's registered read returns data one cycle after cpu_addr.
REQ-024 cpu_run is registered: it rises the cycle RUN is entered and falls the cycle after a start pulse in RUN.
REQ-025 Index and length are 16-bit; index never reaches MEM_DEPTH due to REQ-019.
REQ-026 rx_valid high while rx_ready low does not consume a byte.
REQ-027 ERR holds until start or reset; no memory writes in ERR.

Reset
REQ-028 rst_n low: state IDLE; index, length, and checksum cleared; rx_ready, mem_write_en, cpu_run, busy, error = 0; mem_addr, mem_instr_in = 0.
REQ-029 Reset mid-load abandons the load immediately; words already written remain in memory (the memory has no reset).
REQ-030 Reset release: remain in IDLE until start.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN enables a trailing checksum byte.
REQ-032 Defined: an 8-bit running sum, modulo 256, covers both length bytes and all data bytes, and is cleared on entry to LEN_LO.
REQ-033 Defined: end-of-data and the len=0 path go to CHK; accepted byte equal to the sum -> RUN, else -> ERR. Undefined: CHK is never entered, end-of-data goes to RUN, and only length overflow causes ERR.

Verification
REQ-034 Load len=2 words 0x0026,0x0101 (bytes 02 00 26 00 01 01) -> writes addr0=0x0026, addr1=0x0101; then cpu_run=1; with macro, checksum byte 0x2A is required.
REQ-035 Length 0x00B6 (182) -> ERR, error=1, zero writes, rx_ready=0.
REQ-036 rx_valid toggled every other cycle during a 3-word load -> same three writes, with none duplicated or dropped.
REQ-037 rst_n asserted after word 1 of 3 is written -> all outputs 0 in the same cycle, state IDLE, and the next start reloads from index 0.
REQ-038 In RUN, cpu_addr=5 -> mem_addr=5 the same cycle; start pulse -> cpu_run=0 the next cycle and rx_ready=1.
REQ-039 Macro defined, wrong checksum byte -> ERR, cpu_run remains 0.
